bit_index_serializer: RTL and testbench

- Parametrised successor to the single-word index-of-one block. Accepts a BW-bit word with a valid/ready handshake, then emits the index of every set bit, one index per beat, on an output valid/ready stream.
- Adds a runtime scan direction (LSB-first or MSB-first), a last-beat flag, a popcount, a zero-word marker and full output backpressure.
- Sits between bit-vector producers (request masks, flag registers) and index-consuming logic.

---
 rtl/bit_index_serializer.sv | 113 +++++++++++
 tb/tb_bit_index_serializer.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/bit_index_serializer.sv
// Accepts a BW-bit word and streams out the index of every set bit,
// LSB-first or MSB-first, with popcount, zero-word marker and last flag.
module bit_index_serializer #(
    parameter  int BW = 8,
    localparam int IW = $clog2(BW),
    localparam int CW = $clog2(BW + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_vld,
    output logic          in_rdy,
    input  logic [BW-1:0] in1,
    input  logic          in_msb_first,
    output logic          out_vld,
    input  logic          out_rdy,
    output logic [IW-1:0] out_index,
    output logic          out_last,
    output logic          out_none,
    output logic [CW-1:0] out_pop
);

    typedef enum logic {
        IDLE,
        EMIT
    } state_t;

    state_t        state_q, state_d;
    logic [BW-1:0] mask_q, mask_d;
    logic          dir_q, dir_d;
    logic          none_q, none_d;
    logic [CW-1:0] pop_q, pop_d;

    logic [IW-1:0] idx_lo, idx_hi, cur_idx;
    logic          one_hot, cur_last;
    logic [CW-1:0] pop_in;

    // Scan direction picks the first-hit priority encoder.
    always_comb begin
        idx_lo = '0;
        for (int i = BW - 1; i >= 0; i--) begin
            if (mask_q[i]) idx_lo = IW'(i);
        end
        idx_hi = '0;
        for (int i = 0; i < BW; i++) begin
            if (mask_q[i]) idx_hi = IW'(i);
        end
        cur_idx  = none_q ? '0 : (dir_q ? idx_hi : idx_lo);
        one_hot  = (mask_q != '0) &&
                   ((mask_q & (mask_q - BW'(1))) == '0);
        cur_last = (state_q == EMIT) && (none_q || one_hot);
    end

    always_comb begin
        pop_in = '0;
        for (int i = 0; i < BW; i++) begin
            pop_in = pop_in + CW'(in1[i]);
        end
    end

    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        dir_d   = dir_q;
        none_d  = none_q;
        pop_d   = pop_q;
        unique case (state_q)
            IDLE: begin
                if (in_vld) begin
                    state_d = EMIT;
                    mask_d  = in1;
                    dir_d   = in_msb_first;
                    none_d  = (in1 == '0);
                    pop_d   = pop_in;
                end
            end
            EMIT: begin
                if (out_rdy) begin
                    mask_d = mask_q & ~(BW'(1) << cur_idx);
                    if (cur_last) begin
                        state_d = IDLE;
                        mask_d  = '0;
                        none_d  = 1'b0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            mask_q  <= '0;
            dir_q   <= 1'b0;
            none_q  <= 1'b0;
            pop_q   <= '0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            dir_q   <= dir_d;
            none_q  <= none_d;
            pop_q   <= pop_d;
        end
    end

    assign in_rdy    = (state_q == IDLE);
    assign out_vld   = (state_q == EMIT);
    assign out_index = cur_idx;
    assign out_last  = cur_last;
    assign out_none  = none_q;
    assign out_pop   = pop_q;

endmodule

// File: tb/tb_bit_index_serializer.sv
// Directed bench for bit_index_serializer at BW=8; inputs driven and
// outputs sampled on the falling edge.
module tb_bit_index_serializer;

    localparam int BW = 8;
    localparam int IW = $clog2(BW);
    localparam int CW = $clog2(BW + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_vld = 1'b0;
    logic          in_rdy;
    logic [BW-1:0] in1 = '0;
    logic          in_msb_first = 1'b0;
    logic          out_vld;
    logic          out_rdy = 1'b1;
    logic [IW-1:0] out_index;
    logic          out_last;
    logic          out_none;
    logic [CW-1:0] out_pop;

    int n_cmp = 0;
    int n_bad = 0;
    int beats = 0;

    bit_index_serializer #(.BW(BW)) dut (
        .clk(clk), .rst(rst),
        .in_vld(in_vld), .in_rdy(in_rdy),
        .in1(in1), .in_msb_first(in_msb_first),
        .out_vld(out_vld), .out_rdy(out_rdy),
        .out_index(out_index), .out_last(out_last),
        .out_none(out_none), .out_pop(out_pop)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!rst && out_vld && out_rdy) beats++;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called at a falling edge; returns at the falling edge after acceptance.
    task automatic accept(input logic [BW-1:0] w, input logic dir);
        in_vld = 1'b1;
        in1 = w;
        in_msb_first = dir;
        chk("acc_rdy", 32'(in_rdy), 1);
        @(posedge clk);
        @(negedge clk);
        in_vld = 1'b0;
    endtask

    task automatic beat(input string tag, input int idx, input bit last,
                        input bit none, input int pop);
        chk({tag, "_vld"}, 32'(out_vld), 1);
        chk({tag, "_idx"}, 32'(out_index), 32'(idx));
        chk({tag, "_last"}, 32'(out_last), 32'(last));
        chk({tag, "_none"}, 32'(out_none), 32'(none));
        chk({tag, "_pop"}, 32'(out_pop), 32'(pop));
        @(negedge clk);
    endtask

    task automatic idle(input string tag, input int pop);
        chk({tag, "_vld"}, 32'(out_vld), 0);
        chk({tag, "_rdy"}, 32'(in_rdy), 1);
        chk({tag, "_none"}, 32'(out_none), 0);
        chk({tag, "_pop"}, 32'(out_pop), 32'(pop));
    endtask

    initial begin
        int b0;
        bit rdy_pat [5] = '{0, 0, 1, 0, 1};
        int idx_pat [5] = '{4, 4, 4, 6, 6};
        bit lst_pat [5] = '{0, 0, 0, 1, 1};

        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst_rdy", 32'(in_rdy), 1);
        chk("rst_vld", 32'(out_vld), 0);
        chk("rst_idx", 32'(out_index), 0);
        chk("rst_last", 32'(out_last), 0);
        chk("rst_none", 32'(out_none), 0);
        chk("rst_pop", 32'(out_pop), 0);

        accept(8'b1000_1001, 1'b0);
        beat("lsb0", 0, 0, 0, 3);
        beat("lsb1", 3, 0, 0, 3);
        beat("lsb2", 7, 1, 0, 3);
        idle("lsb_idle", 3);

        accept(8'b1000_1001, 1'b1);
        beat("msb0", 7, 0, 0, 3);
        beat("msb1", 3, 0, 0, 3);
        beat("msb2", 0, 1, 0, 3);
        idle("msb_idle", 3);

        accept(8'h00, 1'b0);
        beat("zero", 0, 1, 1, 0);
        idle("zero_idle", 0);

        accept(8'hFF, 1'b0);
        for (int i = 0; i < 8; i++)
            beat($sformatf("ff%0d", i), i, i == 7, 0, 8);
        idle("ff_idle", 8);

        out_rdy = 1'b0;
        b0 = beats;
        accept(8'b0101_0000, 1'b0);
        for (int i = 0; i < 5; i++) begin
            out_rdy = rdy_pat[i];
            beat($sformatf("bp%0d", i), idx_pat[i], lst_pat[i], 0, 2);
        end
        out_rdy = 1'b1;
        idle("bp_idle", 2);
        chk("bp_beats", 32'(beats - b0), 2);

        in_vld = 1'b1;
        in1 = 8'h81;
        in_msb_first = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in1 = 8'h02;
        chk("b2b_rdy0", 32'(in_rdy), 0);
        beat("b2b0", 0, 0, 0, 2);
        chk("b2b_rdy1", 32'(in_rdy), 0);
        beat("b2b1", 7, 1, 0, 2);
        idle("b2b_gap", 2);
        @(negedge clk);
        in_vld = 1'b0;
        beat("b2b2", 1, 1, 0, 1);
        idle("b2b_idle", 1);

        accept(8'hF0, 1'b0);
        beat("rst0", 4, 0, 0, 4);
        chk("rst_mid_idx", 32'(out_index), 5);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        idle("rst_after", 0);
        chk("rst_after_idx", 32'(out_index), 0);
        accept(8'h01, 1'b0);
        beat("one", 0, 1, 0, 1);
        idle("one_idle", 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
